// File: rtl/mem_org_pkg.sv
// Shared types and defaults for the memory-organization mode programmer.
// The FSM encoding and counter-width helper live here.
package mem_org_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRd,
    StRdWait,
    StRetry
  } state_e;

  localparam int unsigned DefConduitWidth = 2;
  localparam int unsigned DefCfgAddr      = 0;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_org_cfg_master_if.sv
// Host request handshake plus Avalon-MM master bus for the mode programmer.
// The master modport is the programmer's view; slave is the host/slave-side view.
interface mem_org_cfg_master_if
  import mem_org_pkg::*;
#(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned CONDUIT_WIDTH = DefConduitWidth,
  parameter int unsigned ADDR_WIDTH    = 4
);

  logic                     req_valid;
  logic                     req_ready;
  logic [CONDUIT_WIDTH-1:0] req_mode;

  logic [ADDR_WIDTH-1:0]    master_address;
  logic                     master_write;
  logic                     master_read;
  logic [WIDTH-1:0]         master_writedata;
  logic [WIDTH-1:0]         master_readdata;
  logic                     master_readdatavalid;
  logic                     master_waitrequest;

  modport master (
    input  req_valid,
    input  req_mode,
    output req_ready,
    output master_address,
    output master_write,
    output master_read,
    output master_writedata,
    input  master_readdata,
    input  master_readdatavalid,
    input  master_waitrequest
  );

  modport slave (
    output req_valid,
    output req_mode,
    input  req_ready,
    input  master_address,
    input  master_write,
    input  master_read,
    input  master_writedata,
    output master_readdata,
    output master_readdatavalid,
    output master_waitrequest
  );

endinterface

// File: rtl/mem_org_timeout_cnt.sv
// Loadable up-counter that saturates at Limit and flags when it sits there.
// Used to bound the wait for read data.
module mem_org_timeout_cnt
  import mem_org_pkg::*;
#(
  parameter  int unsigned Limit = 15,
  localparam int unsigned CntW  = cnt_width(Limit)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  input  logic            en_i,
  output logic            tc_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != CntW'(Limit))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CntW'(Limit));

endmodule

// File: rtl/mem_org_cfg_master.sv
// Avalon-MM master that writes the memory-organization mode register on request.
// MEM_ORG_READBACK_EN adds read-back verification with timeout and bounded retry.
module mem_org_cfg_master
  import mem_org_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned CONDUIT_WIDTH  = DefConduitWidth,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned CFG_ADDR       = DefCfgAddr,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic                     clk,
  input  logic                     resetn,
  mem_org_cfg_master_if.master     bus,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [CONDUIT_WIDTH-1:0] current_mode
);

  state_e                   state_q, state_d;
  logic [CONDUIT_WIDTH-1:0] mode_q, mode_d;
  logic [CONDUIT_WIDTH-1:0] cur_q, cur_d;
  logic                     done_q, done_d;
  logic                     unused_rdata;

`ifdef MEM_ORG_READBACK_EN
  localparam int unsigned RetryW = cnt_width(MAX_RETRIES);
  localparam int unsigned ToutW  = cnt_width(TIMEOUT_CYCLES - 1);

  logic [RetryW-1:0] retry_q, retry_d;
  logic              error_q, error_d;
  logic              tout_load, tout_en, tout_tc;
  logic              rd_match;

  mem_org_timeout_cnt #(
    .Limit (TIMEOUT_CYCLES - 1)
  ) u_timeout_cnt (
    .clk        (clk),
    .resetn     (resetn),
    .load_i     (tout_load),
    .load_val_i (ToutW'(0)),
    .en_i       (tout_en),
    .tc_o       (tout_tc)
  );

  assign rd_match = (bus.master_readdata[CONDUIT_WIDTH-1:0] == mode_q);
`else
  localparam int unsigned UnusedCfg = TIMEOUT_CYCLES + MAX_RETRIES;
  logic unused_rdv;
  assign unused_rdv = bus.master_readdatavalid;
`endif

  assign unused_rdata = ^bus.master_readdata;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cur_d   = cur_q;
    done_d  = 1'b0;
`ifdef MEM_ORG_READBACK_EN
    retry_d   = retry_q;
    error_d   = 1'b0;
    tout_load = 1'b0;
    tout_en   = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          mode_d  = bus.req_mode;
`ifdef MEM_ORG_READBACK_EN
          retry_d = '0;
`endif
          state_d = StWr;
        end
      end
      StWr: begin
        if (!bus.master_waitrequest) begin
`ifdef MEM_ORG_READBACK_EN
          state_d = StRd;
`else
          done_d  = 1'b1;
          cur_d   = mode_q;
          state_d = StIdle;
`endif
        end
      end
`ifdef MEM_ORG_READBACK_EN
      StRd: begin
        if (!bus.master_waitrequest) begin
          tout_load = 1'b1;
          state_d   = StRdWait;
        end
      end
      StRdWait: begin
        tout_en = 1'b1;
        // Data arriving on the terminal cycle takes priority over the timeout.
        if (bus.master_readdatavalid) begin
          if (rd_match) begin
            done_d  = 1'b1;
            cur_d   = mode_q;
            state_d = StIdle;
          end else begin
            state_d = StRetry;
          end
        end else if (tout_tc) begin
          state_d = StRetry;
        end
      end
      StRetry: begin
        if (retry_q < RetryW'(MAX_RETRIES)) begin
          retry_d = retry_q + 1'b1;
          state_d = StWr;
        end else begin
          error_d = 1'b1;
          state_d = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      mode_q  <= '0;
      cur_q   <= '0;
      done_q  <= 1'b0;
`ifdef MEM_ORG_READBACK_EN
      retry_q <= '0;
      error_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cur_q   <= cur_d;
      done_q  <= done_d;
`ifdef MEM_ORG_READBACK_EN
      retry_q <= retry_d;
      error_q <= error_d;
`endif
    end
  end

  // Command outputs decode straight from state, so they hold through waitrequest.
  assign bus.req_ready        = (state_q == StIdle);
  assign bus.master_address   = ADDR_WIDTH'(CFG_ADDR);
  assign bus.master_write     = (state_q == StWr);
  assign bus.master_writedata = WIDTH'(mode_q);
`ifdef MEM_ORG_READBACK_EN
  assign bus.master_read      = (state_q == StRd);
  assign error                = error_q;
`else
  assign bus.master_read      = 1'b0;
  assign error                = 1'b0;
`endif

  assign busy         = (state_q != StIdle);
  assign done         = done_q;
  assign current_mode = cur_q;

endmodule

// File: tb/tb_mem_org_cfg_master.sv
// Directed bench for mem_org_cfg_master with a reactive Avalon slave model.
// Read-back scenarios are added when MEM_ORG_READBACK_EN is defined.
module tb_mem_org_cfg_master;

`ifdef MEM_ORG_READBACK_EN
  localparam bit Rb = 1'b1;
`else
  localparam bit Rb = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       busy, done, error;
  logic [1:0] current_mode;

  always #5 clk = ~clk;

  mem_org_cfg_master_if #(
    .WIDTH         (32),
    .CONDUIT_WIDTH (2),
    .ADDR_WIDTH    (4)
  ) bus ();

  mem_org_cfg_master #(
    .WIDTH          (32),
    .CONDUIT_WIDTH  (2),
    .ADDR_WIDTH     (4),
    .CFG_ADDR       (0),
    .TIMEOUT_CYCLES (16),
    .MAX_RETRIES    (3)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .current_mode (current_mode)
  );

  int tests = 0;
  int fails = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Slave configuration and observed-activity counters.
  int          wr_stall = 0, rd_stall = 0, rdv_delay = 1;
  bit          echo = 1'b1;
  logic [31:0] resp_default = '0;
  logic [31:0] resp_q[$];
  int          wr_cnt = 0, rd_cnt = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
  logic [31:0] last_wdata = '0;

  initial begin : slave
    bit          active = 1'b0, stalled = 1'b0;
    int          stall_left = 0, pend = 0;
    logic        snap_w = 1'b0, snap_r = 1'b0;
    logic [31:0] snap_d = '0;
    logic [3:0]  snap_a = '0;
    bus.master_waitrequest   = 1'b0;
    bus.master_readdatavalid = 1'b0;
    bus.master_readdata      = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.master_readdatavalid = 1'b0;
      if (!resetn) begin
        active = 1'b0; stalled = 1'b0; pend = 0;
        bus.master_waitrequest = 1'b0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            bus.master_readdatavalid = 1'b1;
            if (echo) bus.master_readdata = last_wdata;
            else if (resp_q.size() > 0) bus.master_readdata = resp_q.pop_front();
            else bus.master_readdata = resp_default;
          end
        end
        if (stalled) begin
          check_eq("hold_write", {31'b0, bus.master_write}, {31'b0, snap_w});
          check_eq("hold_read", {31'b0, bus.master_read}, {31'b0, snap_r});
          check_eq("hold_wdata", bus.master_writedata, snap_d);
          check_eq("hold_addr", {28'b0, bus.master_address}, {28'b0, snap_a});
        end
        if (bus.master_write && bus.master_read) both_cnt++;
        if (bus.master_write || bus.master_read) begin
          if (!active) begin
            active = 1'b1;
            stall_left = bus.master_write ? wr_stall : rd_stall;
          end
          if (stall_left > 0) begin
            stall_left--;
            bus.master_waitrequest = 1'b1;
            stalled = 1'b1;
            snap_w = bus.master_write; snap_r = bus.master_read;
            snap_d = bus.master_writedata; snap_a = bus.master_address;
          end else begin
            bus.master_waitrequest = 1'b0;
            stalled = 1'b0;
            active = 1'b0;
            if (bus.master_write) begin
              wr_cnt++;
              last_wdata = bus.master_writedata;
            end else begin
              rd_cnt++;
              pend = rdv_delay;
            end
          end
        end else begin
          bus.master_waitrequest = 1'b0;
          stalled = 1'b0;
        end
      end
    end
  end

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
      if (error) err_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int w0, r0, d0, e0, bc;

  task automatic snap();
    w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt; e0 = err_cnt;
  endtask

  // Issue one request from IDLE and count cycles spent busy after the accept edge.
  task automatic run_req(input logic [1:0] mode, output int busy_cyc);
    bus.req_mode  = mode;
    bus.req_valid = 1'b1;
    tick(1);
    bus.req_valid = 1'b0;
    check_eq("ready_drop", {31'b0, bus.req_ready}, 32'd0);
    busy_cyc = 0;
    while (busy && busy_cyc < 2000) begin
      busy_cyc++;
      tick(1);
    end
    if (busy) check_eq("busy_bound", {31'b0, busy}, 32'd0);
    tick(1);
  endtask

  task automatic check_run(input string tag, input int ebc, input int ew, input int er,
                           input int ed, input int ee);
    check_eq({tag, "_cycles"}, bc, ebc);
    check_eq({tag, "_writes"}, wr_cnt - w0, ew);
    check_eq({tag, "_reads"}, rd_cnt - r0, er);
    check_eq({tag, "_done"}, done_cnt - d0, ed);
    check_eq({tag, "_error"}, err_cnt - e0, ee);
  endtask

  initial begin : main
    bus.req_valid = 1'b0;
    bus.req_mode  = '0;
    tick(2);
    check_eq("rst_ready", {31'b0, bus.req_ready}, 32'd1);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_write", {31'b0, bus.master_write}, 32'd0);
    check_eq("rst_read", {31'b0, bus.master_read}, 32'd0);
    check_eq("rst_done", {31'b0, done}, 32'd0);
    check_eq("rst_error", {31'b0, error}, 32'd0);
    check_eq("rst_mode", {30'b0, current_mode}, 32'd0);
    check_eq("rst_wdata", bus.master_writedata, 32'd0);
    check_eq("rst_addr", {28'b0, bus.master_address}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    tick(1);

    // Basic: mode 2 echoed back.
    snap();
    run_req(2'b10, bc);
    check_run("basic", Rb ? 3 : 1, 1, Rb ? 1 : 0, 1, 0);
    check_eq("basic_wdata", last_wdata, 32'h0000_0002);
    check_eq("basic_mode", {30'b0, current_mode}, 32'd2);
    check_eq("basic_ready", {31'b0, bus.req_ready}, 32'd1);

    // Stall: 5 cycles on the write, 3 on the read.
    wr_stall = 5; rd_stall = 3;
    snap();
    run_req(2'b01, bc);
    check_run("stall", Rb ? 11 : 6, 1, Rb ? 1 : 0, 1, 0);
    check_eq("stall_wdata", last_wdata, 32'h0000_0001);
    check_eq("stall_mode", {30'b0, current_mode}, 32'd1);
    wr_stall = 0; rd_stall = 0;

    snap();
    run_req(2'b11, bc);
    check_run("mode3", Rb ? 3 : 1, 1, Rb ? 1 : 0, 1, 0);
    check_eq("mode3_mode", {30'b0, current_mode}, 32'd3);
    run_req(2'b00, bc);
    check_eq("mode0_wdata", last_wdata, 32'h0000_0000);
    check_eq("mode0_mode", {30'b0, current_mode}, 32'd0);

`ifdef MEM_ORG_READBACK_EN
    // Exhaustion: slave always answers 3 for a request of 1.
    echo = 1'b0; resp_default = 32'd3;
    snap();
    run_req(2'b01, bc);
    check_run("exhaust", 16, 4, 4, 0, 1);
    check_eq("exhaust_mode", {30'b0, current_mode}, 32'd0);

    // Mismatch twice, then correct.
    resp_q = '{32'd0, 32'd0, 32'd1};
    snap();
    run_req(2'b01, bc);
    check_run("retry", 11, 3, 3, 1, 0);
    check_eq("retry_mode", {30'b0, current_mode}, 32'd1);

    // No read data at all: 16 wait cycles per attempt, four attempts.
    rdv_delay = 0;
    snap();
    run_req(2'b10, bc);
    check_run("timeout", 76, 4, 4, 0, 1);
    check_eq("timeout_mode", {30'b0, current_mode}, 32'd1);

    // Read data on the terminal wait cycle is still accepted.
    rdv_delay = 16; echo = 1'b1;
    snap();
    run_req(2'b10, bc);
    check_run("terminal", 18, 1, 1, 1, 0);
    check_eq("terminal_mode", {30'b0, current_mode}, 32'd2);
    rdv_delay = 1;
`endif

    // Reset mid-transaction: parked in the read wait, or in a stalled write.
    if (Rb) rdv_delay = 0;
    else wr_stall = 1000;
    snap();
    bus.req_mode  = 2'b11;
    bus.req_valid = 1'b1;
    tick(1);
    bus.req_valid = 1'b0;
    tick(3);
    check_eq("pre_rst_busy", {31'b0, busy}, 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check_eq("arst_busy", {31'b0, busy}, 32'd0);
    check_eq("arst_ready", {31'b0, bus.req_ready}, 32'd1);
    check_eq("arst_write", {31'b0, bus.master_write}, 32'd0);
    check_eq("arst_read", {31'b0, bus.master_read}, 32'd0);
    check_eq("arst_mode", {30'b0, current_mode}, 32'd0);
    check_eq("arst_wdata", bus.master_writedata, 32'd0);
    tick(2);
    @(negedge clk);
    resetn = 1'b1;
    wr_stall = 0; rdv_delay = 1; echo = 1'b1;
    tick(1);
    check_eq("arst_no_done", done_cnt - d0, 0);
    check_eq("arst_no_error", err_cnt - e0, 0);

    snap();
    run_req(2'b11, bc);
    check_run("post_rst", Rb ? 3 : 1, 1, Rb ? 1 : 0, 1, 0);
    check_eq("post_rst_mode", {30'b0, current_mode}, 32'd3);

    check_eq("wr_rd_exclusive", both_cnt, 0);
    if (!Rb) check_eq("no_reads", rd_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
